// File: rtl/footswitch_bypass_ctrl.sv
// footswitch_bypass_ctrl: debounced footswitches toggle/panic-clear effect slots with click-free dry/wet crossfades
// Optional feature macro FSW_LED_BLINK_EN: slot LEDs blink while their crossfade is in progress.
module footswitch_bypass_ctrl #(
   parameter int DATA_WIDTH = 16,
   parameter int NUM_SLOTS = 4,
   parameter int NUM_BUTTONS = 3,
   parameter logic [NUM_BUTTONS*NUM_SLOTS-1:0] BUTTON_MAP = '0,
   parameter int DEBOUNCE_TICKS = 480,
   parameter int LONG_PRESS_TICKS = 96000,
   parameter int RAMP_LOG2 = 8
) (
   input  logic                            clk_i,
   input  logic                            srst_i,
   input  logic                            sample_tick_i,
   input  logic [NUM_BUTTONS-1:0]          button_i,
   input  logic [NUM_SLOTS*DATA_WIDTH-1:0] dry_i,
   input  logic [NUM_SLOTS*DATA_WIDTH-1:0] wet_i,
   output logic [NUM_SLOTS*DATA_WIDTH-1:0] data_o,
   output logic [NUM_SLOTS-1:0]            enable_o,
   output logic [NUM_SLOTS-1:0]            ramp_busy_o,
   output logic [NUM_SLOTS-1:0]            leds_o
);
   localparam int DCW = $clog2(DEBOUNCE_TICKS + 1);
   localparam int LCW = $clog2(LONG_PRESS_TICKS + 1);
   localparam int GW = RAMP_LOG2 + 1;
   localparam int DW1 = DATA_WIDTH + 1;
   localparam int PW = DATA_WIDTH + RAMP_LOG2 + 2;
   localparam logic [GW-1:0] G_MAX = GW'(2 ** RAMP_LOG2);
   localparam logic [DCW-1:0] DB_LAST = DCW'(DEBOUNCE_TICKS - 1);
   localparam logic [LCW-1:0] LP_LAST = LCW'(LONG_PRESS_TICKS - 1);

   typedef enum logic [1:0] {IDLE, PRESSED, LONG} state_t;

   logic [DCW-1:0] db_cnt [NUM_BUTTONS];
   logic [LCW-1:0] hold [NUM_BUTTONS];
   logic [LCW-1:0] hold_n [NUM_BUTTONS];
   state_t state [NUM_BUTTONS];
   state_t state_n [NUM_BUTTONS];
   logic [NUM_BUTTONS-1:0] deb, armed, toggle, panic;
   logic [NUM_SLOTS-1:0] flip, enable, busy;
   logic [GW-1:0] gain [NUM_SLOTS];
   logic signed [DATA_WIDTH-1:0] dry [NUM_SLOTS];
   logic signed [DATA_WIDTH-1:0] wet [NUM_SLOTS];
   logic signed [DATA_WIDTH:0] diff [NUM_SLOTS];
   logic signed [PW-1:0] prod [NUM_SLOTS];
   logic [DATA_WIDTH-1:0] mix [NUM_SLOTS];

   // Debounce raw levels; a button is armed only once seen fully released, so a press held through reset is ignored
   always_ff @(posedge clk_i) begin
      for (int b = 0; b < NUM_BUTTONS; b++) begin
         if (srst_i || button_i[b] == deb[b]) db_cnt[b] <= '0;
         else if (sample_tick_i) db_cnt[b] <= db_cnt[b] == DB_LAST ? '0 : db_cnt[b] + 1'b1;
         if (srst_i) begin
            deb[b] <= 1'b0;
            armed[b] <= 1'b0;
         end else begin
            if (sample_tick_i && button_i[b] != deb[b] && db_cnt[b] == DB_LAST) deb[b] <= button_i[b];
            armed[b] <= armed[b] | ~(button_i[b] | deb[b]);
         end
      end
   end

   // Button FSM state and hold-counter registers
   always_ff @(posedge clk_i) begin
      for (int b = 0; b < NUM_BUTTONS; b++) begin
         state[b] <= srst_i ? IDLE : state_n[b];
         hold[b] <= srst_i ? '0 : hold_n[b];
      end
   end

   // Button FSM next state: short press emits a toggle on release, long hold emits one panic
   always_comb begin
      toggle = '0;
      panic = '0;
      for (int b = 0; b < NUM_BUTTONS; b++) begin
         state_n[b] = state[b];
         hold_n[b] = hold[b];
         case (state[b])
            IDLE: if (deb[b] && armed[b]) begin
               state_n[b] = PRESSED;
               hold_n[b] = '0;
            end
            PRESSED: if (!deb[b]) begin
               toggle[b] = 1'b1;
               state_n[b] = IDLE;
            end else if (sample_tick_i) begin
               if (hold[b] == LP_LAST) begin
                  panic[b] = 1'b1;
                  state_n[b] = LONG;
               end else hold_n[b] = hold[b] + 1'b1;
            end
            default: if (!deb[b]) state_n[b] = IDLE;
         endcase
      end
   end

   // Map toggle pulses onto slots; simultaneous toggles of one slot cancel
   always_comb begin
      flip = '0;
      for (int b = 0; b < NUM_BUTTONS; b++)
         for (int s = 0; s < NUM_SLOTS; s++)
            flip[s] = flip[s] ^ (toggle[b] & BUTTON_MAP[b*NUM_SLOTS+s]);
   end

   // Enable register; panic wins over any toggle in the same clock
   always_ff @(posedge clk_i) enable <= (srst_i || |panic) ? '0 : enable ^ flip;

   // Crossfade dry + (wet-dry)*g/2**RAMP_LOG2 with a floor shift, always within DATA_WIDTH
   always_comb begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
         dry[s] = $signed(dry_i[s*DATA_WIDTH +: DATA_WIDTH]);
         wet[s] = $signed(wet_i[s*DATA_WIDTH +: DATA_WIDTH]);
         diff[s] = DW1'(wet[s]) - DW1'(dry[s]);
         prod[s] = PW'(diff[s]) * PW'($signed({1'b0, gain[s]}));
         mix[s] = DATA_WIDTH'(PW'(dry[s]) + (prod[s] >>> RAMP_LOG2));
      end
   end

   // Per-tick mix with the pre-step gain, gain ramp toward the enable target, busy flag
   always_ff @(posedge clk_i) begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
         if (srst_i) begin
            gain[s] <= '0;
            busy[s] <= 1'b0;
            data_o[s*DATA_WIDTH +: DATA_WIDTH] <= '0;
         end else begin
            busy[s] <= gain[s] != '0 && gain[s] != G_MAX;
            if (sample_tick_i) begin
               data_o[s*DATA_WIDTH +: DATA_WIDTH] <= mix[s];
               if (enable[s] && gain[s] != G_MAX) gain[s] <= gain[s] + 1'b1;
               else if (!enable[s] && gain[s] != '0) gain[s] <= gain[s] - 1'b1;
            end
         end
      end
   end

   assign enable_o = enable;
   assign ramp_busy_o = busy;

`ifdef FSW_LED_BLINK_EN
   logic [11:0] blink_cnt [NUM_SLOTS];
   logic [NUM_SLOTS-1:0] blink;

   // Flip each LED every 4096 ticks while its slot ramps; idle slots reload from the enable
   always_ff @(posedge clk_i) begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
         if (srst_i) begin
            blink_cnt[s] <= '0;
            blink[s] <= 1'b0;
         end else if (!busy[s]) begin
            blink_cnt[s] <= '0;
            blink[s] <= enable[s];
         end else if (sample_tick_i) begin
            blink_cnt[s] <= blink_cnt[s] + 1'b1;
            if (&blink_cnt[s]) blink[s] <= ~blink[s];
         end
      end
   end

   assign leds_o = (busy & blink) | (~busy & enable);
`else
   assign leds_o = enable;
`endif
endmodule

// File: tb/tb_footswitch_bypass_ctrl.sv
// tb_footswitch_bypass_ctrl: directed checks of debounce, toggle, panic, crossfade and reset
module tb_footswitch_bypass_ctrl;
   logic clk = 1'b0;
   logic srst = 1'b1;
   logic tick = 1'b0;
   logic [1:0] button = '0;
   logic [31:0] dry = '0;
   logic [31:0] wet = '0;
   logic [31:0] data;
   logic [1:0] enable, busy, leds;
   int total = 0;
   int bad = 0;

   footswitch_bypass_ctrl #(
      .DATA_WIDTH(16), .NUM_SLOTS(2), .NUM_BUTTONS(2), .BUTTON_MAP(4'b1101),
      .DEBOUNCE_TICKS(4), .LONG_PRESS_TICKS(16), .RAMP_LOG2(2)
   ) dut (
      .clk_i(clk), .srst_i(srst), .sample_tick_i(tick), .button_i(button),
      .dry_i(dry), .wet_i(wet), .data_o(data), .enable_o(enable),
      .ramp_busy_o(busy), .leds_o(leds)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL timeout: bench did not reach its summary");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_ticks(input int n);
      repeat (n) begin
         @(negedge clk) tick = 1'b1;
         @(negedge clk) tick = 1'b0;
      end
   endtask

   task automatic tk(input logic [1:0] m);
      button = m;
      do_ticks(1);
   endtask

   task automatic press(input logic [1:0] m, input int h);
      button = m;
      do_ticks(h);
      button = '0;
      do_ticks(4);
      idle(1);
   endtask

   logic [15:0] sweep [5] = '{16'h8000, 16'hBFFF, 16'hFFFF, 16'h3FFF, 16'h7FFF};

   initial begin
      idle(3);
      chk("rst_data", data, 32'h0);
      chk("rst_enable", {30'd0, enable}, 32'h0);
      chk("rst_busy", {30'd0, busy}, 32'h0);
      chk("rst_leds", {30'd0, leds}, 32'h0);
      srst = 1'b0;
      idle(2);
      // glitch shorter than the debounce window
      button = 2'b01;
      do_ticks(3);
      button = 2'b00;
      do_ticks(5);
      idle(2);
      chk("glitch_enable", {30'd0, enable}, 32'h0);
      // short press on b0 and ramp up
      dry = {16'd7, 16'd0};
      wet = {16'hFFF9, 16'd400};
      button = 2'b01;
      do_ticks(6);
      button = 2'b00;
      do_ticks(4);
      idle(1);
      chk("press_enable", {30'd0, enable}, 32'h1);
      chk("press_leds", {30'd0, leds}, 32'h1);
      chk("press_data0", {16'd0, data[15:0]}, 32'h0);
      for (int k = 0; k < 5; k++) begin
         do_ticks(1);
         idle(1);
         chk($sformatf("ramp_data0_%0d", k), {16'd0, data[15:0]}, 32'(100 * k));
         chk($sformatf("ramp_busy0_%0d", k), {31'd0, busy[0]}, {31'd0, k < 3});
      end
      chk("ramp_data1", {16'd0, data[31:16]}, 32'd7);
      // toggle combinations
      press(2'b01, 6);
      chk("off_enable", {30'd0, enable}, 32'h0);
      press(2'b11, 6);
      chk("dual_enable", {30'd0, enable}, 32'h2);
      press(2'b01, 6);
      chk("both_enable", {30'd0, enable}, 32'h3);
      do_ticks(6);
      idle(1);
      chk("full_data0", {16'd0, data[15:0]}, 32'd400);
      chk("full_data1", {16'd0, data[31:16]}, 32'h0000FFF9);
      chk("full_busy", {30'd0, busy}, 32'h0);
      // long press panic
      button = 2'b10;
      do_ticks(20);
      idle(1);
      chk("panic_enable", {30'd0, enable}, 32'h0);
      chk("panic_busy", {30'd0, busy}, 32'h0);
      button = 2'b00;
      do_ticks(1);
      idle(1);
      chk("panic_ramp_busy", {30'd0, busy}, 32'h3);
      chk("panic_ramp_data0", {16'd0, data[15:0]}, 32'd400);
      do_ticks(3);
      idle(1);
      chk("panic_release_enable", {30'd0, enable}, 32'h0);
      chk("panic_release_busy", {30'd0, busy}, 32'h0);
      do_ticks(1);
      idle(1);
      chk("panic_dry", data, {16'd7, 16'd0});
      // enable slot0, then b1 flips it back off at g0=2
      tk(2'b01); tk(2'b01); tk(2'b01); tk(2'b11); tk(2'b11);
      tk(2'b10); tk(2'b10); tk(2'b00); tk(2'b00);
      idle(1);
      chk("rev_enable_on", {30'd0, enable}, 32'h1);
      tk(2'b00);
      tk(2'b00);
      idle(1);
      chk("rev_enable_flip", {30'd0, enable}, 32'h2);
      chk("rev_data0_a", {16'd0, data[15:0]}, 32'd100);
      do_ticks(1);
      idle(1);
      chk("rev_data0_b", {16'd0, data[15:0]}, 32'd200);
      chk("rev_busy0_b", {31'd0, busy[0]}, 32'h1);
      do_ticks(1);
      idle(1);
      chk("rev_data0_c", {16'd0, data[15:0]}, 32'd100);
      chk("rev_busy0_c", {31'd0, busy[0]}, 32'h0);
      do_ticks(1);
      idle(1);
      chk("rev_data0_dry", {16'd0, data[15:0]}, 32'd0);
      // full-scale sweep
      dry[15:0] = 16'h8000;
      wet[15:0] = 16'h7FFF;
      press(2'b01, 6);
      chk("sweep_enable", {30'd0, enable}, 32'h3);
      for (int k = 0; k < 5; k++) begin
         do_ticks(1);
         idle(1);
         chk($sformatf("sweep_%0d", k), {16'd0, data[15:0]}, {16'd0, sweep[k]});
      end
      // reset mid-ramp with b0 held through it
      press(2'b01, 6);
      do_ticks(2);
      idle(1);
      chk("mid_busy0", {31'd0, busy[0]}, 32'h1);
      button = 2'b01;
      srst = 1'b1;
      idle(1);
      chk("srst_data", data, 32'h0);
      chk("srst_enable", {30'd0, enable}, 32'h0);
      chk("srst_busy", {30'd0, busy}, 32'h0);
      chk("srst_leds", {30'd0, leds}, 32'h0);
      srst = 1'b0;
      do_ticks(8);
      button = 2'b00;
      do_ticks(6);
      idle(1);
      chk("held_through_reset", {30'd0, enable}, 32'h0);
      press(2'b01, 6);
      chk("repress_enable", {30'd0, enable}, 32'h1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
